// File: rtl/roi_band_centroid.sv
// roi_band_centroid: X centroid of thresholded pixels for each horizontal band at the bottom of the frame.
// Optional macro CENTROID_WEIGHTED_EN weights every active pixel by its value instead of counting it.
module roi_band_centroid #(
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 480,
    parameter int unsigned PIX_W     = 4,
    parameter int unsigned THRESHOLD = 0,
    parameter int unsigned NUM_BANDS = 4,
    parameter int unsigned BAND_H    = 32,
    localparam int unsigned XW       = $clog2(IMG_W),
    localparam int unsigned BW       = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1,
`ifdef CENTROID_WEIGHTED_EN
    localparam int unsigned WEXT     = PIX_W,
`else
    localparam int unsigned WEXT     = 0,
`endif
    localparam int unsigned SPW      = $clog2(BAND_H*IMG_W+1) + WEXT,
    localparam int unsigned SXW      = SPW + XW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sof,
    input  logic [PIX_W-1:0] pixel_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW-1:0]    out_band,
    output logic [XW-1:0]    out_centroid_x,
    output logic [SPW-1:0]   out_count,
    output logic             out_lost,
    output logic             frame_done,
    output logic             overrun
);

    localparam int unsigned RW      = $clog2(IMG_H+1);
    localparam int unsigned CW      = $clog2(SXW+1);
    localparam int unsigned ROI_TOP = IMG_H - NUM_BANDS*BAND_H;

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

    state_t         state;
    logic [XW-1:0]  col, eff_col;
    logic [RW-1:0]  row, eff_row, rel_row;
    logic [SXW-1:0] acc_x, base_x, add_x, slot_x, div_q, q_next;
    logic [SPW-1:0] acc_p, base_p, add_p, slot_p, div_d, div_r, r_next;
    logic [SPW:0]   trial;
    logic [BW-1:0]  band_idx, slot_band, div_band;
    logic [CW-1:0]  div_cnt;
    logic           active, in_roi, last_col, band_end, last_pix, take, slot_full, ge;

    // Beat position decode; a sof beat is always column 0 of row 0
    always_comb begin
        eff_col  = sof ? '0 : col;
        eff_row  = sof ? '0 : row;
        rel_row  = eff_row - RW'(ROI_TOP);
        in_roi   = eff_row >= RW'(ROI_TOP);
        last_col = eff_col == XW'(IMG_W-1);
        band_idx = BW'(rel_row / RW'(BAND_H));
        band_end = in_roi && last_col && ((rel_row % RW'(BAND_H)) == RW'(BAND_H-1));
        last_pix = last_col && (eff_row == RW'(IMG_H-1));
        active   = pixel_in > PIX_W'(THRESHOLD);
        base_x   = sof ? '0 : acc_x;
        base_p   = sof ? '0 : acc_p;
`ifdef CENTROID_WEIGHTED_EN
        add_x    = active ? SXW'(eff_col) * SXW'(pixel_in) : '0;
        add_p    = active ? SPW'(pixel_in) : '0;
`else
        add_x    = active ? SXW'(eff_col) : '0;
        add_p    = active ? SPW'(1) : '0;
`endif
        take     = (state == IDLE) && slot_full;
    end

    // One restoring-division step: shift in the next dividend bit, subtract when it fits
    always_comb begin
        trial  = {div_r, div_q[SXW-1]};
        ge     = trial >= {1'b0, div_d};
        r_next = ge ? SPW'(trial - {1'b0, div_d}) : trial[SPW-1:0];
        q_next = {div_q[SXW-2:0], ge};
    end

    // Raster counters, band accumulators and the single-entry capture slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            acc_x      <= '0;
            acc_p      <= '0;
            slot_full  <= 1'b0;
            slot_x     <= '0;
            slot_p     <= '0;
            slot_band  <= '0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= in_valid && last_pix;
            if (take) slot_full <= 1'b0;
            if (in_valid) begin
                if (last_col) begin
                    col <= '0;
                    row <= (eff_row == RW'(IMG_H-1)) ? '0 : eff_row + RW'(1);
                end else begin
                    col <= eff_col + XW'(1);
                    row <= eff_row;
                end
                if (sof) overrun <= 1'b0;
                if (band_end) begin
                    acc_x <= '0;
                    acc_p <= '0;
                    // A slot being consumed this cycle counts as free
                    if (slot_full && !take) begin
                        overrun <= 1'b1;
                    end else begin
                        slot_full <= 1'b1;
                        slot_x    <= base_x + add_x;
                        slot_p    <= base_p + add_p;
                        slot_band <= band_idx;
                    end
                end else if (in_roi) begin
                    acc_x <= base_x + add_x;
                    acc_p <= base_p + add_p;
                end else begin
                    acc_x <= base_x;
                    acc_p <= base_p;
                end
            end
        end
    end

    // Divider / result FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            div_q          <= '0;
            div_d          <= '0;
            div_r          <= '0;
            div_band       <= '0;
            div_cnt        <= '0;
            out_valid      <= 1'b0;
            out_band       <= '0;
            out_centroid_x <= '0;
            out_count      <= '0;
            out_lost       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (slot_full) begin
                        div_q    <= slot_x;
                        div_d    <= slot_p;
                        div_r    <= '0;
                        div_band <= slot_band;
                        div_cnt  <= '0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    div_q   <= q_next;
                    div_r   <= r_next;
                    div_cnt <= div_cnt + CW'(1);
                    if (div_cnt == CW'(SXW-1)) begin
                        state          <= HOLD;
                        out_valid      <= 1'b1;
                        out_band       <= div_band;
                        out_count      <= div_d;
                        out_lost       <= div_d == '0;
                        out_centroid_x <= (div_d == '0) ? '0 : q_next[XW-1:0];
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_roi_band_centroid.sv
// Testbench for roi_band_centroid on a 16x8 frame with two 2-row bands.
// Fixed vectors, hand-written corner sequences and random frames checked against a per-band reference model.
module tb_roi_band_centroid;

    localparam int unsigned IMG_W   = 16;
    localparam int unsigned IMG_H   = 8;
    localparam int unsigned NB      = 2;
    localparam int unsigned BH      = 2;
    localparam int unsigned PIX_W   = 4;
    localparam int unsigned THR     = 0;
    localparam int unsigned NPIX    = IMG_W*IMG_H;
    localparam int unsigned ROI_TOP = IMG_H - NB*BH;
`ifdef CENTROID_WEIGHTED_EN
    localparam int unsigned SPW     = $clog2(BH*IMG_W+1) + PIX_W;
`else
    localparam int unsigned SPW     = $clog2(BH*IMG_W+1);
`endif
    localparam int unsigned LAT     = SPW + 4 + 2;

    typedef struct {
        int band;
        int cx;
        int cnt;
        int lost;
    } res_t;

    typedef struct {
        int r0, r1, c0, c1, val;
        int cx0, n0, l0, cx1, n1, l1;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, sof, out_ready;
    logic [PIX_W-1:0] pixel_in;
    logic             out_valid, out_lost, frame_done, overrun;
    logic [0:0]       out_band;
    logic [3:0]       out_centroid_x;
    logic [SPW-1:0]   out_count;

    logic [PIX_W-1:0] pix [NPIX];
    res_t got[$];
    res_t expq[$];
    int   rises[$];
    int   cyc = 0;
    int   t_b0end = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic prev_valid = 1'b0;
    logic rand_rdy = 1'b0;

    roi_band_centroid #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .THRESHOLD(THR),
        .NUM_BANDS(NB), .BAND_H(BH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sof(sof), .pixel_in(pixel_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_band(out_band),
        .out_centroid_x(out_centroid_x), .out_count(out_count), .out_lost(out_lost),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every accepted result and every rising edge of out_valid
    always @(negedge clk) begin
        res_t r;
        prev_valid <= out_valid;
        if (out_valid && !prev_valid) rises.push_back(cyc);
        if (out_valid && out_ready) begin
            r.band = int'(out_band);
            r.cx   = int'(out_centroid_x);
            r.cnt  = int'(out_count);
            r.lost = int'(out_lost);
            got.push_back(r);
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic step();
        if (rand_rdy) out_ready = ($urandom_range(3) != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_rect(input int r0, input int r1, input int c0, input int c1, input int v);
        for (int i = 0; i < int'(NPIX); i++) pix[i] = '0;
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++) pix[r*IMG_W+c] = PIX_W'(v);
    endtask

    // Reference: per band, sum positions (or position*value) of pixels above threshold and divide
    task automatic model_frame();
        res_t e;
        for (int b = 0; b < int'(NB); b++) begin
            int sx = 0;
            int sp = 0;
            for (int r = ROI_TOP + b*BH; r < int'(ROI_TOP + (b+1)*BH); r++)
                for (int c = 0; c < int'(IMG_W); c++) begin
                    int v = int'(pix[r*IMG_W+c]);
                    if (v > int'(THR)) begin
`ifdef CENTROID_WEIGHTED_EN
                        sx += c*v;
                        sp += v;
`else
                        sx += c;
                        sp += 1;
`endif
                    end
                end
            e.band = b;
            e.cnt  = sp;
            e.lost = (sp == 0) ? 1 : 0;
            e.cx   = (sp == 0) ? 0 : sx / sp;
            expq.push_back(e);
        end
    endtask

    // Drive nbeats raster beats from pix; optional idle gaps with a random (ignored) sof
    task automatic drive_frame(input int nbeats, input int gap_pct);
        for (int i = 0; i < nbeats; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                sof      = 1'($urandom_range(1));
                pixel_in = PIX_W'($urandom);
                step();
            end
            in_valid = 1'b1;
            sof      = (i == 0);
            pixel_in = pix[i];
            if (i == int'((ROI_TOP+BH)*IMG_W) - 1) t_b0end = cyc;
            step();
        end
        in_valid = 1'b0;
        sof      = 1'b0;
        pixel_in = '0;
    endtask

    task automatic wait_results(input int n);
        for (int k = 0; k < 1500 && got.size() < n; k++) step();
    endtask

    task automatic compare_all(input string tag);
        res_t e, g;
        check({tag, " result count"}, got.size(), expq.size());
        while (expq.size() > 0 && got.size() > 0) begin
            e = expq.pop_front();
            g = got.pop_front();
            check($sformatf("%s b%0d band", tag, e.band), g.band, e.band);
            check($sformatf("%s b%0d centroid", tag, e.band), g.cx, e.cx);
            check($sformatf("%s b%0d count", tag, e.band), g.cnt, e.cnt);
            check($sformatf("%s b%0d lost", tag, e.band), g.lost, e.lost);
        end
        expq.delete();
        got.delete();
    endtask

    task automatic push_exp(input int b, input int cx, input int n, input int l);
        res_t e;
        e.band = b; e.cx = cx; e.cnt = n; e.lost = l;
        expq.push_back(e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{4, 5, 5, 7, 15,   6, 6, 0,   0, 0, 1};
        tbl[1] = '{7, 7, 15, 15, 1,  0, 0, 1,  15, 1, 0};
        tbl[2] = '{4, 7, 0, 15, 1,   7, 32, 0,  7, 32, 0};
        tbl[3] = '{6, 6, 0, 0, 3,    0, 0, 1,   0, 1, 0};
        tbl[4] = '{0, 3, 0, 15, 9,   0, 0, 1,   0, 0, 1};
        tbl[5] = '{5, 6, 10, 13, 2,  11, 4, 0, 11, 4, 0};

        rst_n = 1'b0; in_valid = 1'b0; sof = 1'b0; pixel_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_band", int'(out_band), 0);
        check("reset out_centroid_x", int'(out_centroid_x), 0);
        check("reset out_count", int'(out_count), 0);
        check("reset out_lost", int'(out_lost), 1);
        check("reset frame_done", int'(frame_done), 0);
        check("reset overrun", int'(overrun), 0);
        rst_n = 1'b1;
        step();

`ifndef CENTROID_WEIGHTED_EN
        // Fixed vectors with hand-derived results
        foreach (tbl[i]) begin
            set_rect(tbl[i].r0, tbl[i].r1, tbl[i].c0, tbl[i].c1, tbl[i].val);
            push_exp(0, tbl[i].cx0, tbl[i].n0, tbl[i].l0);
            push_exp(1, tbl[i].cx1, tbl[i].n1, tbl[i].l1);
            rises.delete();
            drive_frame(NPIX, 0);
            check($sformatf("vec%0d frame_done pulse", i), int'(frame_done), 1);
            step();
            check($sformatf("vec%0d frame_done low", i), int'(frame_done), 0);
            wait_results(2);
            if (i == 0) check("vec0 latency", (rises.size() > 0) ? rises[0] - t_b0end : -1, int'(LAT));
            compare_all($sformatf("vec%0d", i));
        end
`else
        set_rect(0, -1, 0, -1, 0);
        pix[6*IMG_W+4] = 4'd3;
        pix[6*IMG_W+8] = 4'd1;
        push_exp(0, 0, 0, 1);
        push_exp(1, 5, 4, 0);
        drive_frame(NPIX, 0);
        wait_results(2);
        compare_all("weighted");
`endif

        // Backpressure: band0 holds, band1 fills the slot, next frame's bands are dropped
        out_ready = 1'b0;
        set_rect(4, 5, 5, 7, 15);
        model_frame();
        drive_frame(NPIX, 0);
        check("bp hold valid A", int'(out_valid), 1);
        check("bp hold centroid A", int'(out_centroid_x), expq[0].cx);
        set_rect(5, 6, 10, 13, 2);
        drive_frame(NPIX, 0);
        repeat (20) step();
        check("bp hold valid B", int'(out_valid), 1);
        check("bp hold band B", int'(out_band), 0);
        check("bp hold centroid B", int'(out_centroid_x), expq[0].cx);
        check("bp hold count B", int'(out_count), expq[0].cnt);
        check("bp overrun set", int'(overrun), 1);
        out_ready = 1'b1;
        wait_results(2);
        compare_all("bp drain");
        check("bp overrun sticky", int'(overrun), 1);
        set_rect(7, 7, 15, 15, 1);
        model_frame();
        drive_frame(NPIX, 0);
        check("bp overrun cleared", int'(overrun), 0);
        wait_results(2);
        compare_all("bp after");

        // Mid-frame sof at row 5 col 3 discards the partial band0
        set_rect(4, 5, 5, 7, 15);
        drive_frame(5*IMG_W + 3, 0);
        set_rect(7, 7, 15, 15, 1);
        model_frame();
        drive_frame(NPIX, 0);
        wait_results(2);
        repeat (40) step();
        compare_all("midsof");

        // Reset while dividing, then while holding
        set_rect(5, 6, 10, 13, 2);
        drive_frame(100, 0);
        rst_n = 1'b0;
        #1;
        check("rst div out_valid", int'(out_valid), 0);
        check("rst div out_lost", int'(out_lost), 1);
        check("rst div overrun", int'(overrun), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b0;
        drive_frame(NPIX, 0);
        repeat (5) step();
        check("rst hold precondition", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst hold out_valid", int'(out_valid), 0);
        check("rst hold out_lost", int'(out_lost), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        got.delete();
        set_rect(4, 7, 0, 15, 1);
        model_frame();
        drive_frame(NPIX, 0);
        wait_results(2);
        compare_all("post reset");

        // Random frames with input gaps and random backpressure
        rand_rdy = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < int'(NPIX); i++)
                pix[i] = ($urandom_range(2) == 0) ? PIX_W'($urandom_range(15)) : '0;
            if (f == 2)
                for (int i = int'(ROI_TOP*IMG_W); i < int'((ROI_TOP+BH)*IMG_W); i++) pix[i] = '0;
            model_frame();
            drive_frame(NPIX, 20);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        wait_results(12);
        compare_all("random");
        check("random no overrun", int'(overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/roi_band_centroid.md
Name: roi_band_centroid

Overview:
- Successor line-position tracker for the pixel pipeline; sits after thresholding, ahead of steering control.
- Splits the bottom of each frame into NUM_BANDS stacked horizontal bands of BAND_H rows each.
- Computes each band's X centroid with an in-block serial divider, so no divider IP is used.
- Streams one result per band over a valid/ready output, with lost-line and overrun reporting.

Parameters:
- IMG_W, 640: pixels per row.
- IMG_H, 480: rows per frame.
- PIX_W, 4: pixel width.
- THRESHOLD, 0: a pixel is active when pixel_in > THRESHOLD.
- NUM_BANDS, 4: number of bands, >= 1. Band 0 is the topmost band of the ROI.
- BAND_H, 32: rows per band. NUM_BANDS*BAND_H <= IMG_H.
- Localparams:
  - XW = $clog2(IMG_W)
  - BW = max(1, $clog2(NUM_BANDS))
  - SPW = $clog2(BAND_H*IMG_W+1)
  - SXW = SPW+XW
  - With CENTROID_WEIGHTED_EN, SPW and SXW each grow by PIX_W.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: pixel beat qualifier.
- sof, in, 1: start of frame; sampled only with in_valid.
- pixel_in, in, PIX_W: raster-order pixel.
- out_valid, out, 1: band result available.
- out_ready, in, 1: consumer accepts the result.
- out_band, out, BW: band index of the result.
- out_centroid_x, out, XW: floor(sum_x/sum_p).
- out_count, out, SPW: band active-pixel count (weight sum when weighted).
- out_lost, out, 1: band had sum_p == 0.
- frame_done, out, 1: 1-cycle pulse on the accepted last pixel of the frame.
- overrun, out, 1: sticky flag that a band result was dropped.

Behaviour:
- Reset (rst_n low, async): all counters and accumulators 0; FSM to IDLE; capture slot empty. Outputs: out_valid=0, out_band=0, out_centroid_x=0, out_count=0, out_lost=1, frame_done=0, overrun=0.
- Counting:
  - col and row advance only on in_valid.
  - col wraps IMG_W-1 -> 0, then row increments; row wraps IMG_H-1 -> 0.
  - in_valid&&sof forces that beat to be col=0,row=0. Partial band accumulators are discarded; divider and output state are untouched.
- ROI: rows IMG_H-NUM_BANDS*BAND_H .. IMG_H-1. Band b covers BAND_H consecutive rows starting at IMG_H-(NUM_BANDS-b)*BAND_H.
- Accumulation per active beat inside the ROI: sum_x += col, sum_p += 1.
- Band end is the beat at col==IMG_W-1 on the band's last row.
  - That beat's contribution is included.
  - {sum_x, sum_p, b} move to the capture slot in the same cycle; the accumulators clear.
  - If the slot is already full: drop the new band, set overrun. overrun clears on the next sof beat.
- FSM:
  - IDLE: slot full -> DIV. Load the divider, free the slot.
  - DIV: restoring divide, 1 quotient bit per cycle, SXW cycles, then -> HOLD.
  - HOLD: out_valid=1 and all out_* stable. On out_valid&&out_ready -> IDLE. A new result may start no earlier than the next cycle.
- Latency:
  - Band end beat at cycle T, slot loaded T+1, FSM in IDLE at T+1 -> divider load.
  - out_valid rises at T+SXW+2 when the FSM is idle.
  - out_valid is never dropped without acceptance.
- Lost band (sum_p==0): the divider still runs (uniform latency). out_centroid_x=0, out_lost=1, out_count=0.
- Quotient is truncated to XW bits; it always fits because sum_x/sum_p <= IMG_W-1.
- Simultaneous band end and HOLD acceptance: both take effect; the slot fills and IDLE consumes it next cycle.

Optional Feature:
- CENTROID_WEIGHTED_EN defined:
  - An active beat adds sum_x += col*pixel_in and sum_p += pixel_in.
  - Widths widen by PIX_W; out_count is the weight sum.
  - Latency becomes SXW(widened)+2.
- Undefined: binary counting as above.

Test Plan (IMG_W=16, IMG_H=8, NUM_BANDS=2, BAND_H=2, PIX_W=4, THRESHOLD=0, so SXW=10 and latency=12; out_ready=1 unless stated):
- Basic band and lost band:
  - Stimulus: sof, frame with pixel 15 at cols 5..7 in rows 4,5, else 0.
  - Response: band0 has centroid=6, count=6, lost=0. out_valid rises 12 cycles after row-5 col-15 beat. band1 has lost=1, centroid=0.
- Edge column:
  - Stimulus: a single active pixel at col 15 of row 7.
  - Response: band1 has centroid=15, count=1.
- Backpressure and overrun:
  - Stimulus: out_ready=0 for two frames.
  - Response: band0 held stable in HOLD; band1 fills the slot; the next frame's band0 is dropped and overrun=1 until the next sof.
- Mid-frame sof:
  - Stimulus: sof asserted at row 5 col 3.
  - Response: partial band0 discarded, counting restarts at row 0, no spurious output.
- Reset mid-divide:
  - Stimulus: rst_n low during DIV.
  - Response: out_valid=0, out_lost=1, overrun=0 immediately. The next frame produces correct results.
- Weighted (CENTROID_WEIGHTED_EN):
  - Stimulus: col 4 = 3 and col 8 = 1 in row 6, rest 0.
  - Response: band1 has count=4, centroid=floor(20/4)=5.
